// File: rtl/coax_txrx_sequencer_if.sv
// Control/datapath bundle for coax_txrx_sequencer; slave = sequencer, master = its environment.
// Stats signals exist only when COAX_SEQ_STATS_EN is defined.
interface coax_txrx_sequencer_if;
   logic       cmd_strobe;
   logic       cmd_expect_rsp;
   logic       cmd_abort;
   logic       busy;
   logic       done;
   logic [1:0] result;
   logic       tx_enable;
   logic       tx_active;
   logic       tx_empty;
   logic       rx_enable;
   logic       rx_reset;
   logic       rx_active;
   logic       rx_error;
`ifdef COAX_SEQ_STATS_EN
   logic        stat_clear;
   logic [15:0] stat_xact;
   logic [7:0]  stat_timeout;
   logic [7:0]  stat_error;
`endif

   modport slave (
      input  cmd_strobe, cmd_expect_rsp, cmd_abort, tx_active, tx_empty, rx_active, rx_error,
`ifdef COAX_SEQ_STATS_EN
      input  stat_clear,
      output stat_xact, stat_timeout, stat_error,
`endif
      output busy, done, result, tx_enable, rx_enable, rx_reset
   );

   modport master (
      output cmd_strobe, cmd_expect_rsp, cmd_abort, tx_active, tx_empty, rx_active, rx_error,
`ifdef COAX_SEQ_STATS_EN
      output stat_clear,
      input  stat_xact, stat_timeout, stat_error,
`endif
      input  busy, done, result, tx_enable, rx_enable, rx_reset
   );
endinterface

// File: rtl/coax_txrx_sequencer.sv
// Half-duplex coax transaction sequencer: TX release, line-turnaround guard, RX response wait.
// All outputs registered (one clock after the deciding input); COAX_SEQ_STATS_EN adds saturating counters.
module coax_txrx_sequencer #(
   parameter int TX_START_TIMEOUT = 64,
   parameter int GUARD_CLOCKS     = 16,
   parameter int RESPONSE_TIMEOUT = 217
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   coax_txrx_sequencer_if.slave  bus
);

   localparam int MAX_AB = (TX_START_TIMEOUT > GUARD_CLOCKS) ? TX_START_TIMEOUT : GUARD_CLOCKS;
   localparam int MAX_P  = (MAX_AB > RESPONSE_TIMEOUT) ? MAX_AB : RESPONSE_TIMEOUT;
   localparam int CW     = $clog2(MAX_P + 1);

   localparam logic [1:0] RES_OK      = 2'b00;
   localparam logic [1:0] RES_TIMEOUT = 2'b01;
   localparam logic [1:0] RES_RX_ERR  = 2'b10;
   localparam logic [1:0] RES_TX_FLT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_TX_START, S_TX, S_GUARD, S_RX_WAIT, S_RX, S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            expect_q, expect_d;
   logic [1:0]      result_q, result_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tx_en_q, tx_en_d;
   logic            rx_en_q, rx_en_d;
   logic            rx_rst_q, rx_rst_d;

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         expect_q <= 1'b0;
         result_q <= RES_OK;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tx_en_q  <= 1'b0;
         rx_en_q  <= 1'b0;
         rx_rst_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         expect_q <= expect_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         tx_en_q  <= tx_en_d;
         rx_en_q  <= rx_en_d;
         rx_rst_q <= rx_rst_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      expect_d = expect_q;
      result_d = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_strobe && !bus.cmd_abort) begin
               state_d  = S_TX_START;
               expect_d = bus.cmd_expect_rsp;
            end
         end
         S_TX_START: begin
            cnt_d = cnt_inc;
            if (bus.tx_active) begin
               state_d = S_TX;
            end else if (cnt_inc == CW'(TX_START_TIMEOUT)) begin
               state_d  = S_DONE;
               result_d = bus.tx_empty ? RES_OK : RES_TX_FLT;
            end
         end
         S_TX: begin
            if (!bus.tx_active) begin
               if (expect_q) begin
                  state_d = S_GUARD;
               end else begin
                  state_d  = S_DONE;
                  result_d = RES_OK;
               end
            end
         end
         S_GUARD: begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(GUARD_CLOCKS)) state_d = S_RX_WAIT;
         end
         S_RX_WAIT: begin
            cnt_d = cnt_inc;
            // Activity is checked before expiry so a response landing on the last clock is kept.
            if (bus.rx_error) begin
               state_d  = S_DONE;
               result_d = RES_RX_ERR;
            end else if (bus.rx_active) begin
               state_d = S_RX;
            end else if (cnt_inc == CW'(RESPONSE_TIMEOUT)) begin
               state_d  = S_DONE;
               result_d = RES_TIMEOUT;
            end
         end
         S_RX: begin
            if (bus.rx_error) begin
               state_d  = S_DONE;
               result_d = RES_RX_ERR;
            end else if (!bus.rx_active) begin
               state_d  = S_DONE;
               result_d = RES_OK;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE && bus.cmd_abort) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
      if (state_d != state_q) cnt_d = '0;
   end

   // Outputs are decoded from the next state so they appear registered, aligned with the state.
   always_comb begin
      busy_d   = (state_d == S_TX_START) || (state_d == S_TX) || (state_d == S_GUARD) ||
                 (state_d == S_RX_WAIT) || (state_d == S_RX);
      done_d   = (state_d == S_DONE);
      tx_en_d  = (state_d == S_TX_START) || (state_d == S_TX);
      rx_en_d  = (state_d == S_RX_WAIT) || (state_d == S_RX);
      rx_rst_d = (state_q == S_IDLE) && (state_d == S_TX_START);
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.tx_enable = tx_en_q;
   assign bus.rx_enable = rx_en_q;
   assign bus.rx_reset  = rx_rst_q;

`ifdef COAX_SEQ_STATS_EN
   logic [15:0] stat_xact_q;
   logic [7:0]  stat_to_q, stat_err_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stat_xact_q <= '0;
         stat_to_q   <= '0;
         stat_err_q  <= '0;
      end else if (bus.stat_clear) begin
         stat_xact_q <= '0;
         stat_to_q   <= '0;
         stat_err_q  <= '0;
      end else if (state_d == S_DONE) begin
         if (stat_xact_q != '1) stat_xact_q <= stat_xact_q + 1'b1;
         if (result_d == RES_TIMEOUT && stat_to_q != '1) stat_to_q <= stat_to_q + 1'b1;
         if (result_d[1] && stat_err_q != '1) stat_err_q <= stat_err_q + 1'b1;
      end
   end

   assign bus.stat_xact    = stat_xact_q;
   assign bus.stat_timeout = stat_to_q;
   assign bus.stat_error   = stat_err_q;
`endif

endmodule

// File: tb/tb_coax_txrx_sequencer.sv
// Scoreboarded bench for coax_txrx_sequencer; stats checks compile in with COAX_SEQ_STATS_EN.
module tb_coax_txrx_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   coax_txrx_sequencer_if ifc();
   coax_txrx_sequencer dut (.clk_i(clk), .rst_n_i(rst_n), .bus(ifc.slave));

   int errors = 0;
   int checks = 0;
   logic [1:0] sb[$];
   logic [1:0] sb_exp;
   int rst_pulses = 0;
   int done_cnt = 0;
   bit rx_seen = 1'b0;

   // Output monitor: scoreboard pop on done, enable exclusivity every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (ifc.tx_enable && ifc.rx_enable) begin
            errors++;
            $display("FAIL enable_mutex: tx_enable=%b rx_enable=%b, required not both high", ifc.tx_enable, ifc.rx_enable);
         end
         if (ifc.rx_reset) rst_pulses++;
         if (ifc.rx_enable) rx_seen = 1'b1;
         if (ifc.done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: result=%b, required no done", ifc.result);
            end else begin
               sb_exp = sb.pop_front();
               if (ifc.result !== sb_exp) begin
                  errors++;
                  $display("FAIL result: got %b, required %b", ifc.result, sb_exp);
               end
            end
         end
      end
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit exp_rsp, input bit push, input logic [1:0] res);
      ifc.cmd_expect_rsp = exp_rsp;
      ifc.cmd_strobe = 1'b1;
      if (push) sb.push_back(res);
      tick();
      ifc.cmd_strobe = 1'b0;
   endtask

   // Short TX burst then wait (bounded) for rx_enable.
   task automatic reach_rx_wait;
      int n;
      ifc.tx_active = 1'b1;
      repeat (3) tick();
      ifc.tx_active = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!ifc.rx_enable && n < 100);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({ifc.busy, ifc.done, ifc.tx_enable, ifc.rx_enable, ifc.rx_reset, ifc.result} !== 7'b0) begin
         errors++;
         $display("FAIL reset_values: got %b, required 0000000",
                  {ifc.busy, ifc.done, ifc.tx_enable, ifc.rx_enable, ifc.rx_reset, ifc.result});
      end
      rst_n = 1'b1;
      repeat (2) tick();
      start(1'b0, 1'b0, 2'b00);
      ifc.tx_active = 1'b1;
      repeat (5) tick();
      checks++;
      if (ifc.tx_enable !== 1'b1 || ifc.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_tx_state: tx_enable=%b busy=%b, required 1 1", ifc.tx_enable, ifc.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ifc.busy, ifc.done, ifc.tx_enable, ifc.rx_enable, ifc.rx_reset, ifc.result} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset: got %b, required 0000000",
                  {ifc.busy, ifc.done, ifc.tx_enable, ifc.rx_enable, ifc.rx_reset, ifc.result});
      end
      ifc.tx_active = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (ifc.busy !== 1'b0 || ifc.tx_enable !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b tx_enable=%b, required 0 0", ifc.busy, ifc.tx_enable);
      end
   endtask

   task automatic test_no_rsp;
      rst_pulses = 0;
      rx_seen = 1'b0;
      start(1'b0, 1'b1, 2'b00);
      checks++;
      if (ifc.busy !== 1'b1 || ifc.rx_reset !== 1'b1 || ifc.tx_enable !== 1'b1) begin
         errors++;
         $display("FAIL accept: busy=%b rx_reset=%b tx_enable=%b, required 1 1 1", ifc.busy, ifc.rx_reset, ifc.tx_enable);
      end
      ifc.tx_active = 1'b1;
      repeat (40) tick();
      ifc.tx_active = 1'b0;
      tick();
      checks++;
      if (ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.tx_enable !== 1'b0) begin
         errors++;
         $display("FAIL no_rsp_done: done=%b busy=%b tx_enable=%b, required 1 0 0", ifc.done, ifc.busy, ifc.tx_enable);
      end
      tick();
      checks++;
      if (rst_pulses !== 1 || rx_seen !== 1'b0 || ifc.done !== 1'b0) begin
         errors++;
         $display("FAIL no_rsp_side: rx_reset pulses=%0d rx_seen=%b done=%b, required 1 0 0", rst_pulses, rx_seen, ifc.done);
      end
   endtask

   task automatic test_rsp_ok;
      int n;
      start(1'b1, 1'b1, 2'b00);
      ifc.tx_active = 1'b1;
      repeat (20) tick();
      ifc.tx_active = 1'b0;
      tick();
      n = 1;
      checks++;
      if (ifc.tx_enable !== 1'b0 || ifc.rx_enable !== 1'b0) begin
         errors++;
         $display("FAIL tx_enable_drop: tx_enable=%b rx_enable=%b, required 0 0", ifc.tx_enable, ifc.rx_enable);
      end
      while (!ifc.rx_enable && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL guard_len: rx_enable after %0d clocks, required 17", n);
      end
      repeat (9) tick();
      ifc.rx_active = 1'b1;
      repeat (250) tick();
      checks++;
      if (ifc.done !== 1'b0 || ifc.rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL rx_no_timeout: done=%b rx_enable=%b, required 0 1", ifc.done, ifc.rx_enable);
      end
      ifc.rx_active = 1'b0;
      tick();
      checks++;
      if (ifc.done !== 1'b1 || ifc.rx_enable !== 1'b0) begin
         errors++;
         $display("FAIL rsp_ok_done: done=%b rx_enable=%b, required 1 0", ifc.done, ifc.rx_enable);
      end
      tick();
   endtask

   task automatic test_rsp_timeout;
      int n;
      start(1'b1, 1'b1, 2'b01);
      reach_rx_wait();
      n = 0;
      do begin tick(); n++; end while (!ifc.done && n < 300);
      checks++;
      if (n !== 217) begin
         errors++;
         $display("FAIL rsp_timeout_len: done after %0d clocks, required 217", n);
      end
      tick();
      start(1'b1, 1'b1, 2'b00);
      reach_rx_wait();
      repeat (216) tick();
      ifc.rx_active = 1'b1;
      tick();
      checks++;
      if (ifc.done !== 1'b0 || ifc.rx_enable !== 1'b1) begin
         errors++;
         $display("FAIL race_rx_wins: done=%b rx_enable=%b, required 0 1", ifc.done, ifc.rx_enable);
      end
      repeat (3) tick();
      ifc.rx_active = 1'b0;
      tick();
      checks++;
      if (ifc.done !== 1'b1) begin
         errors++;
         $display("FAIL race_done: done=%b, required 1", ifc.done);
      end
      tick();
   endtask

   task automatic test_tx_start;
      int n;
      ifc.tx_empty = 1'b0;
      start(1'b0, 1'b1, 2'b11);
      n = 0;
      do begin tick(); n++; end while (!ifc.done && n < 100);
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL tx_fault_len: done after %0d clocks, required 64", n);
      end
      tick();
      ifc.tx_empty = 1'b1;
      start(1'b1, 1'b1, 2'b00);
      n = 0;
      do begin tick(); n++; end while (!ifc.done && n < 100);
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL tx_empty_len: done after %0d clocks, required 64", n);
      end
      ifc.tx_empty = 1'b0;
      tick();
   endtask

   task automatic test_rx_error;
      start(1'b1, 1'b1, 2'b10);
      reach_rx_wait();
      ifc.rx_active = 1'b1;
      repeat (5) tick();
      ifc.rx_error = 1'b1;
      tick();
      checks++;
      if (ifc.done !== 1'b1) begin
         errors++;
         $display("FAIL rx_error_in_rx: done=%b, required 1", ifc.done);
      end
      ifc.rx_error = 1'b0;
      ifc.rx_active = 1'b0;
      tick();
      start(1'b1, 1'b1, 2'b10);
      reach_rx_wait();
      ifc.rx_error = 1'b1;
      tick();
      checks++;
      if (ifc.done !== 1'b1) begin
         errors++;
         $display("FAIL rx_error_in_wait: done=%b, required 1", ifc.done);
      end
      ifc.rx_error = 1'b0;
      tick();
   endtask

   task automatic test_abort;
      int dc;
      dc = done_cnt;
      start(1'b1, 1'b0, 2'b00);
      reach_rx_wait();
      repeat (5) tick();
      ifc.cmd_abort = 1'b1;
      tick();
      ifc.cmd_abort = 1'b0;
      checks++;
      if (ifc.rx_enable !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_rx_wait: rx_enable=%b busy=%b done=%b, required 0 0 0", ifc.rx_enable, ifc.busy, ifc.done);
      end
      repeat (5) tick();
      checks++;
      if (done_cnt !== dc) begin
         errors++;
         $display("FAIL abort_no_done: done pulses=%0d, required %0d", done_cnt, dc);
      end
      ifc.cmd_abort = 1'b1;
      ifc.cmd_strobe = 1'b1;
      tick();
      ifc.cmd_abort = 1'b0;
      ifc.cmd_strobe = 1'b0;
      checks++;
      if ({ifc.busy, ifc.rx_reset, ifc.tx_enable} !== 3'b000) begin
         errors++;
         $display("FAIL abort_beats_strobe: busy/rx_reset/tx_enable=%b, required 000", {ifc.busy, ifc.rx_reset, ifc.tx_enable});
      end
      tick();
   endtask

   task automatic test_back_to_back;
      start(1'b0, 1'b1, 2'b00);
      ifc.tx_active = 1'b1;
      repeat (3) tick();
      ifc.cmd_strobe = 1'b1;
      tick();
      ifc.cmd_strobe = 1'b0;
      checks++;
      if (ifc.busy !== 1'b1 || ifc.rx_reset !== 1'b0 || ifc.tx_enable !== 1'b1) begin
         errors++;
         $display("FAIL strobe_ignored: busy=%b rx_reset=%b tx_enable=%b, required 1 0 1", ifc.busy, ifc.rx_reset, ifc.tx_enable);
      end
      ifc.tx_active = 1'b0;
      tick();
      checks++;
      if (ifc.done !== 1'b1) begin
         errors++;
         $display("FAIL busy_xact_done: done=%b, required 1", ifc.done);
      end
      tick();
      checks++;
      if (sb.size() !== 0 || ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL scoreboard_drained: pending=%0d done=%b busy=%b, required 0 0 0", sb.size(), ifc.done, ifc.busy);
      end
   endtask

`ifdef COAX_SEQ_STATS_EN
   task automatic test_stats;
      int n;
      ifc.stat_clear = 1'b1;
      tick();
      ifc.stat_clear = 1'b0;
      checks++;
      if (ifc.stat_xact !== 16'd0 || ifc.stat_timeout !== 8'd0 || ifc.stat_error !== 8'd0) begin
         errors++;
         $display("FAIL stat_clear: xact=%0d timeout=%0d error=%0d, required 0 0 0", ifc.stat_xact, ifc.stat_timeout, ifc.stat_error);
      end
      for (int i = 0; i < 260; i++) begin
         start(1'b1, 1'b1, 2'b01);
         ifc.tx_active = 1'b1;
         tick();
         ifc.tx_active = 1'b0;
         n = 0;
         do begin tick(); n++; end while (!ifc.done && n < 400);
         tick();
      end
      checks++;
      if (ifc.stat_xact !== 16'd260 || ifc.stat_timeout !== 8'd255 || ifc.stat_error !== 8'd0) begin
         errors++;
         $display("FAIL stat_saturate: xact=%0d timeout=%0d error=%0d, required 260 255 0", ifc.stat_xact, ifc.stat_timeout, ifc.stat_error);
      end
      start(1'b0, 1'b1, 2'b11);
      n = 0;
      do begin tick(); n++; end while (!ifc.done && n < 100);
      checks++;
      if (ifc.stat_xact !== 16'd261 || ifc.stat_error !== 8'd1) begin
         errors++;
         $display("FAIL stat_error: xact=%0d error=%0d, required 261 1", ifc.stat_xact, ifc.stat_error);
      end
      tick();
      start(1'b0, 1'b1, 2'b11);
      repeat (63) tick();
      ifc.stat_clear = 1'b1;
      tick();
      ifc.stat_clear = 1'b0;
      checks++;
      if (ifc.done !== 1'b1 || ifc.stat_xact !== 16'd0 || ifc.stat_timeout !== 8'd0 || ifc.stat_error !== 8'd0) begin
         errors++;
         $display("FAIL stat_clear_wins: done=%b xact=%0d timeout=%0d error=%0d, required 1 0 0 0",
                  ifc.done, ifc.stat_xact, ifc.stat_timeout, ifc.stat_error);
      end
      tick();
   endtask
`endif

   initial begin
      ifc.cmd_strobe     = 1'b0;
      ifc.cmd_expect_rsp = 1'b0;
      ifc.cmd_abort      = 1'b0;
      ifc.tx_active      = 1'b0;
      ifc.tx_empty       = 1'b0;
      ifc.rx_active      = 1'b0;
      ifc.rx_error       = 1'b0;
`ifdef COAX_SEQ_STATS_EN
      ifc.stat_clear     = 1'b0;
`endif
      test_reset();
      test_no_rsp();
      test_rsp_ok();
      test_rsp_timeout();
      test_tx_start();
      test_rx_error();
      test_abort();
      test_back_to_back();
`ifdef COAX_SEQ_STATS_EN
      test_stats();
`endif
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
